// File: rtl/fifo_wr_arbiter_pkg.sv
// Shared types and default sizing for the FIFO write-port arbiter.
// Optional early-rotation feature is selected by FIFO_ARB_AF_TRUNC_EN.
package fifo_arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } arb_state_t;

  localparam int DEF_N_REQ     = 4;
  localparam int DEF_DATA_W    = 8;
  localparam int DEF_BURST_MAX = 4;

endpackage

// File: rtl/fifo_wr_arbiter_if.sv
// Bundle of producer handshakes and FIFO write-side signals seen by the arbiter.
// master = arbiter side, slave = producers plus FIFO side.
interface fifo_wr_arbiter_if
  import fifo_arb_pkg::*;
#(
  parameter int N_REQ  = DEF_N_REQ,
  parameter int DATA_W = DEF_DATA_W
);
  localparam int ID_W = $clog2(N_REQ);

  logic [N_REQ-1:0]        req_valid;
  logic [N_REQ*DATA_W-1:0] req_data;
  logic [N_REQ-1:0]        req_ready;
  logic                    fifo_full;
  logic                    fifo_almostfull;
  logic                    wr_en;
  logic [DATA_W-1:0]       wr_data;
  logic [ID_W-1:0]         grant_id;
  logic                    busy;

  modport master (
    input  req_valid, req_data, fifo_full, fifo_almostfull,
    output req_ready, wr_en, wr_data, grant_id, busy
  );

  modport slave (
    output req_valid, req_data, fifo_full, fifo_almostfull,
    input  req_ready, wr_en, wr_data, grant_id, busy
  );
endinterface

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Combinational round-robin picker: first valid index at or after i_start,
// wrapping modulo N.
module rr_pick
  import fifo_arb_pkg::*;
#(
  parameter int N = DEF_N_REQ,
  parameter int W = $clog2(N)
) (
  input  logic [N-1:0] i_valid,
  input  logic [W-1:0] i_start,
  output logic [W-1:0] o_winner,
  output logic         o_any
);

  logic [W-1:0] w_idx [N];

  always_comb begin
    for (int i = 0; i < N; i++) begin
      w_idx[i] = W'((int'(i_start) + i) % N);
    end
  end

  // Scan from the farthest offset down so the nearest valid index wins last.
  always_comb begin
    o_winner = '0;
    o_any    = |i_valid;
    for (int i = N - 1; i >= 0; i--) begin
      if (i_valid[w_idx[i]]) begin
        o_winner = w_idx[i];
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing the FIFO write port between N_REQ producers in bounded bursts.
// Define FIFO_ARB_AF_TRUNC_EN to end a burst on any beat accepted while almostfull.
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int N_REQ     = DEF_N_REQ,
  parameter int DATA_W    = DEF_DATA_W,
  parameter int BURST_MAX = DEF_BURST_MAX
) (
  input logic               clk,
  input logic               rst,
  fifo_wr_arbiter_if.master bus
);

  localparam int ID_W  = $clog2(N_REQ);
  localparam int CNT_W = $clog2(BURST_MAX) + 1;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BURST_MAX - 1);
  localparam logic [ID_W-1:0]  LAST_ID   = ID_W'(N_REQ - 1);

  arb_state_t       r_state;
  arb_state_t       w_nextState;
  logic [ID_W-1:0]  r_grant;
  logic [ID_W-1:0]  r_lastGrant;
  logic [CNT_W-1:0] r_beatCnt;

  logic [ID_W-1:0]  w_start;
  logic [ID_W-1:0]  w_winner;
  logic             w_any;
  logic             w_grantValid;
  logic             w_accept;
  logic             w_truncate;
  logic             w_lastBeat;

  assign w_start = (r_lastGrant == LAST_ID) ? '0 : r_lastGrant + 1'b1;

  rr_pick #(.N(N_REQ), .W(ID_W)) u_pick (
    .i_valid  (bus.req_valid),
    .i_start  (w_start),
    .o_winner (w_winner),
    .o_any    (w_any)
  );

  // A full FIFO stalls the owner without ending its burst.
  assign w_grantValid = bus.req_valid[r_grant];
  assign w_accept     = (r_state == BURST) && w_grantValid && !bus.fifo_full;

`ifdef FIFO_ARB_AF_TRUNC_EN
  assign w_truncate = bus.fifo_almostfull;
`else
  assign w_truncate = 1'b0;
`endif

  assign w_lastBeat = w_accept && ((r_beatCnt == LAST_BEAT) || w_truncate);

  always_comb begin
    w_nextState   = r_state;
    bus.wr_en     = w_accept;
    bus.req_ready = w_accept ? (N_REQ'(1) << r_grant) : '0;
    bus.wr_data   = bus.req_data[r_grant*DATA_W +: DATA_W];
    bus.grant_id  = r_grant;
    bus.busy      = (r_state == BURST);
    case (r_state)
      IDLE:    if (w_any) w_nextState = BURST;
      BURST:   if (!w_grantValid || w_lastBeat) w_nextState = IDLE;
      default: w_nextState = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_grant     <= '0;
      r_lastGrant <= LAST_ID;
      r_beatCnt   <= '0;
    end else begin
      r_state <= w_nextState;
      if (r_state == IDLE && w_any) begin
        r_grant   <= w_winner;
        r_beatCnt <= '0;
      end else if (w_accept) begin
        r_beatCnt <= r_beatCnt + 1'b1;
      end
      if (r_state == BURST && w_nextState == IDLE) begin
        r_lastGrant <= r_grant;
      end
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Scoreboard bench for fifo_wr_arbiter: a transaction-level arbitration model pushes per-cycle
// expectations, and a monitor pops them and compares. Honours FIFO_ARB_AF_TRUNC_EN.
module tb_fifo_wr_arbiter;
  import fifo_arb_pkg::*;

  localparam int N  = 4;
  localparam int DW = 8;
  localparam int BM = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  fifo_wr_arbiter_if #(.N_REQ(N), .DATA_W(DW)) bus ();

  fifo_wr_arbiter #(.N_REQ(N), .DATA_W(DW), .BURST_MAX(BM)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic          wrEn;
    logic          busy;
    logic [1:0]    grant;
    logic [DW-1:0] data;
    logic [N-1:0]  ready;
  } exp_t;

  exp_t          expQ[$];
  logic [DW-1:0] dutLog[$];
  int            checks = 0;
  int            errors = 0;

  // Model state: owner is -1 when nobody holds the port.
  int            mOwner = -1;
  int            mBeats = 0;
  int            mLast  = N - 1;
  int            mShown = 0;
  int            seq[N];
  logic [DW-1:0] base[N];

  function automatic logic [DW-1:0] dataOf(int k);
    return base[k] + DW'(seq[k]);
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic modelReset();
    mOwner = -1;
    mBeats = 0;
    mLast  = N - 1;
    mShown = 0;
  endtask

  task automatic endBurst();
    mLast  = mOwner;
    mOwner = -1;
  endtask

  // Clock-edge consequences of one cycle's inputs.
  task automatic modelEdge(input logic [N-1:0] v, input logic acc, input logic af);
    logic trunc;
`ifdef FIFO_ARB_AF_TRUNC_EN
    trunc = af;
`else
    trunc = 1'b0;
`endif
    if (mOwner < 0) begin
      for (int k = 1; k <= N; k++) begin
        if (v[(mLast + k) % N]) begin
          mOwner = (mLast + k) % N;
          mShown = mOwner;
          mBeats = 0;
          break;
        end
      end
    end else if (!v[mOwner]) begin
      endBurst();
    end else if (acc) begin
      seq[mOwner]++;
      mBeats++;
      if (mBeats == BM || trunc) endBurst();
    end
  endtask

  task automatic driveInputs(input logic [N-1:0] v, input logic full, input logic af);
    bus.req_valid       = v;
    bus.fifo_full       = full;
    bus.fifo_almostfull = af;
    for (int k = 0; k < N; k++) bus.req_data[k*DW +: DW] = dataOf(k);
  endtask

  // One full cycle, entered and left at a falling edge.
  task automatic applyStimulus(input logic [N-1:0] v, input logic full, input logic af);
    exp_t e;
    logic acc;
    driveInputs(v, full, af);
    acc = 1'b0;
    if (mOwner >= 0) acc = v[mOwner] && !full;
    e.busy  = (mOwner >= 0);
    e.wrEn  = acc;
    e.grant = 2'(mShown);
    e.data  = dataOf(mShown);
    e.ready = acc ? N'(1 << mOwner) : '0;
    expQ.push_back(e);
    @(posedge clk);
    modelEdge(v, acc, af);
    @(negedge clk);
  endtask

  task automatic doReset();
    driveInputs('1, 1'b0, 1'b0);
    rst = 1'b1;
    #2;
    checkOutput("reset_wr_en", 32'(bus.wr_en), 0);
    checkOutput("reset_req_ready", 32'(bus.req_ready), 0);
    checkOutput("reset_grant_id", 32'(bus.grant_id), 0);
    checkOutput("reset_busy", 32'(bus.busy), 0);
    @(negedge clk);
    rst = 1'b0;
    modelReset();
    for (int k = 0; k < N; k++) seq[k] = 0;
    dutLog.delete();
  endtask

  // Asynchronous reset pulse in the middle of a cycle; outputs must drop at once.
  task automatic resetMid(input logic [N-1:0] v);
    driveInputs(v, 1'b0, 1'b0);
    #3 rst = 1'b1;
    #1;
    checkOutput("midrst_wr_en", 32'(bus.wr_en), 0);
    checkOutput("midrst_req_ready", 32'(bus.req_ready), 0);
    checkOutput("midrst_busy", 32'(bus.busy), 0);
    checkOutput("midrst_grant_id", 32'(bus.grant_id), 0);
    #1 rst = 1'b0;
    modelReset();
    @(posedge clk);
    modelEdge(v, 1'b0, 1'b0);
    @(negedge clk);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (expQ.size() > 0) begin
        e = expQ.pop_front();
        checkOutput("wr_en", 32'(bus.wr_en), 32'(e.wrEn));
        checkOutput("busy", 32'(bus.busy), 32'(e.busy));
        checkOutput("grant_id", 32'(bus.grant_id), 32'(e.grant));
        checkOutput("wr_data", 32'(bus.wr_data), 32'(e.data));
        checkOutput("req_ready", 32'(bus.req_ready), 32'(e.ready));
        if (bus.wr_en === 1'b1) dutLog.push_back(bus.wr_data);
      end
    end
  end

  initial begin : stimulus
    logic [N-1:0] v;
    for (int k = 0; k < N; k++) begin
      base[k] = DW'(k << 4);
      seq[k]  = 0;
    end
    bus.req_valid       = '0;
    bus.req_data        = '0;
    bus.fifo_full       = 1'b0;
    bus.fifo_almostfull = 1'b0;
    @(negedge clk);

    // Single requester sending three beats then dropping valid.
    doReset();
    base[2] = 8'hA0;
    for (int c = 0; c < 6; c++) applyStimulus((seq[2] < 3) ? 4'b0100 : 4'b0000, 1'b0, 1'b0);
    checkOutput("single_count", 32'(dutLog.size()), 3);
    for (int i = 0; i < 3 && i < dutLog.size(); i++)
      checkOutput("single_data", 32'(dutLog[i]), 32'(8'hA0 + i));

    // Fairness: four requesters with four beats each drain in 20 cycles.
    doReset();
    for (int k = 0; k < N; k++) base[k] = DW'(k << 4);
    for (int c = 0; c < 20; c++) begin
      for (int k = 0; k < N; k++) v[k] = (seq[k] < 4);
      applyStimulus(v, 1'b0, 1'b0);
    end
    checkOutput("fair_count", 32'(dutLog.size()), 16);
    for (int i = 0; i < 16 && i < dutLog.size(); i++)
      checkOutput("fair_order", 32'(dutLog[i]), 32'(((i / 4) << 4) + (i % 4)));

    // Full stall after the second beat of requester 1.
    doReset();
    base[1] = 8'h50;
    for (int c = 0; c < 9; c++)
      applyStimulus((seq[1] < 4) ? 4'b0010 : 4'b0000, (c >= 3 && c <= 5), 1'b0);
    checkOutput("stall_count", 32'(dutLog.size()), 4);

    // Reset in the middle of requester 3's burst.
    doReset();
    base[3] = 8'h30;
    applyStimulus(4'b1000, 1'b0, 1'b0);
    applyStimulus(4'b1000, 1'b0, 1'b0);
    resetMid(4'b1111);
    for (int k = 0; k < N; k++) seq[k] = 0;
    applyStimulus(4'b1111, 1'b0, 1'b0);
    applyStimulus(4'b1111, 1'b0, 1'b0);

`ifdef FIFO_ARB_AF_TRUNC_EN
    // Almost-full during the first beat rotates the grant early.
    doReset();
    for (int c = 0; c < 5; c++) applyStimulus(4'b0011, 1'b0, (c == 1));
    checkOutput("af_trunc_count", 32'(dutLog.size()), 3);
`endif

    // Randomized traffic with random stalls and almost-full.
    doReset();
    for (int k = 0; k < N; k++) base[k] = DW'($urandom_range(0, 255));
    for (int c = 0; c < 800; c++) begin
      v = N'($urandom_range(0, (1 << N) - 1));
      applyStimulus(v, ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0));
    end

    @(negedge clk);
    checkOutput("queue_drained", 32'(expQ.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
